// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation codes, immediate formats
// and the decoded-bundle layout carried through the decode stage.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU codes are {alt_bit, funct3}; branches reuse the alt_bit=1 space.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [3:0]  alu_ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
        logic [31:0] v;
        v = '0;
        case (fmt)
            IMM_I:   v = {{20{i[31]}}, i[31:20]};
            IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   v = {i[31:12], 12'b0};
            IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I decoder producing one decoded bundle per word.
module rv32_decode_comb
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    bundle
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    imm_fmt_e   fmt;
    logic       illegal;
    logic [3:0] alu_ctrl;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        fmt      = IMM_R;
        illegal  = 1'b0;
        alu_ctrl = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                alu_ctrl = {instr[30], funct3};
                illegal  = !((funct7 == F7_BASE) ||
                             (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                fmt = IMM_I;
                // Only the shift-right encoding uses instr[30] as an opcode bit; elsewhere it is immediate data.
                case (funct3)
                    3'b001: begin
                        alu_ctrl = {1'b0, funct3};
                        illegal  = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        alu_ctrl = {instr[30], funct3};
                        illegal  = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    default: alu_ctrl = {1'b0, funct3};
                endcase
            end
            OPC_BRANCH: begin
                fmt      = IMM_B;
                alu_ctrl = {1'b1, funct3};
                illegal  = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:          fmt = IMM_S;
            OPC_JAL:            fmt = IMM_J;
            OPC_AUIPC, OPC_LUI: fmt = IMM_U;
            default:            illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_ctrl = ALU_ADD;
        end
    end

    assign bundle = '{
        opcode:   opcode,
        alu_ctrl: alu_ctrl,
        imm:      imm_gen(instr, fmt),
        rs1:      instr[19:15],
        rs2:      instr[24:20],
        rd:       instr[11:7],
        funct3:   funct3,
        illegal:  illegal
    };

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes on the input side and holds up to two decoded bundles
// in a skid buffer so in_ready never depends combinationally on out_ready.
module instr_decode_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  opcode_reg,
    output logic [3:0]  ALUControl_reg,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        illegal
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } buf_state_e;

    buf_state_e state;
    buf_state_e state_nxt;
    decoded_t   dec;
    decoded_t   head;
    decoded_t   tail;
    logic       xfer_in;
    logic       xfer_out;

    rv32_decode_comb u_decode (
        .instr  (instr),
        .bundle (dec)
    );

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (xfer_in) state_nxt = ONE;
                ONE: begin
                    if (xfer_in && !xfer_out)      state_nxt = FULL;
                    else if (!xfer_in && xfer_out) state_nxt = EMPTY;
                end
                FULL:    if (xfer_out) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both entries are cleared asynchronously so no stale bundle is visible during or after reset.
            state    <= EMPTY;
            in_ready <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            // NOTE: non-blocking assignments so head/tail swaps see the pre-edge values.
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
            if (!flush) begin
                case (state)
                    EMPTY: if (xfer_in) head <= dec;
                    ONE: begin
                        if (xfer_in && xfer_out) head <= dec;
                        else if (xfer_in)        tail <= dec;
                    end
                    FULL:    if (xfer_out) head <= tail;
                    default: ;
                endcase
            end
        end
    end

    assign out_valid      = (state != EMPTY);
    assign opcode_reg     = head.opcode;
    assign ALUControl_reg = head.alu_ctrl;
    assign imm            = head.imm;
    assign rs1            = head.rs1;
    assign rs2            = head.rs2;
    assign rd             = head.rd;
    assign funct3         = head.funct3;
    assign illegal        = head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench: a queue-based reference of the stage plus directed
// vectors with hand-computed expectations.
module tb_instr_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  opcode_reg;
    logic [3:0]  ALUControl_reg;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [6:0]  opcode;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        illegal;
    } exp_t;

    exp_t model_q[$];
    logic model_ready;

    instr_decode_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr          (instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .opcode_reg     (opcode_reg),
        .ALUControl_reg (ALUControl_reg),
        .imm            (imm),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .funct3         (funct3),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediates built from weighted field values, then sign-adjusted arithmetically.
    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t        e;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        byte         fmt;
        logic        legal;
        logic [3:0]  alu;
        int          v;
        op    = w[6:0];
        f7    = w[31:25];
        f3    = w[14:12];
        fmt   = "R";
        legal = 1'b1;
        alu   = 4'd0;
        case (op)
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                alu   = {w[30], f3};
            end
            7'h13: begin
                fmt = "I";
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                alu = {(f3 == 3'd5) ? w[30] : 1'b0, f3};
            end
            7'h63: begin
                fmt   = "B";
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                alu   = {1'b1, f3};
            end
            7'h03, 7'h67: fmt = "I";
            7'h23:        fmt = "S";
            7'h6F:        fmt = "J";
            7'h17, 7'h37: fmt = "U";
            default:      legal = 1'b0;
        endcase
        if (!legal) alu = 4'd0;
        case (fmt)
            "I": begin
                v = int'(w[31:20]);
                if (w[31]) v = v - 4096;
            end
            "S": begin
                v = int'(w[31:25]) * 32 + int'(w[11:7]);
                if (w[31]) v = v - 4096;
            end
            "B": begin
                v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                if (w[31]) v = v - 4096;
            end
            "U": v = int'(w & 32'hFFFF_F000);
            "J": begin
                v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                if (w[31]) v = v - 1048576;
            end
            default: v = 0;
        endcase
        e.opcode  = op;
        e.alu     = alu;
        e.imm     = v;
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.rd      = w[11:7];
        e.f3      = f3;
        e.illegal = !legal;
        return e;
    endfunction

    // Reference behaviour: a two-deep FIFO of decoded bundles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_ready = 1'b0;
        end else begin
            logic acc_in;
            logic acc_out;
            acc_in  = in_valid && model_ready;
            acc_out = (model_q.size() != 0) && out_ready;
            if (flush) begin
                model_q.delete();
            end else begin
                if (acc_out) void'(model_q.pop_front());
                if (acc_in)  model_q.push_back(model_decode(instr));
            end
            model_ready = (model_q.size() < 2);
        end
    end

    always @(negedge clk) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, model_ready});
        if (!rst_n) begin
            check("rst_imm", imm, 32'h0);
            check("rst_fields", {opcode_reg, ALUControl_reg, rs1, rs2, rd, funct3, illegal}, 32'h0);
        end else if (model_q.size() != 0) begin
            check("opcode_reg", {25'b0, opcode_reg}, {25'b0, model_q[0].opcode});
            check("ALUControl_reg", {28'b0, ALUControl_reg}, {28'b0, model_q[0].alu});
            check("imm", imm, model_q[0].imm);
            check("regs", {17'b0, rs1, rs2, rd}, {17'b0, model_q[0].rs1, model_q[0].rs2, model_q[0].rd});
            check("funct3", {29'b0, funct3}, {29'b0, model_q[0].f3});
            check("illegal", {31'b0, illegal}, {31'b0, model_q[0].illegal});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] stream [10] = '{
        32'hFFF50513, 32'h00B52223, 32'h123452B7, 32'h0080006F, 32'h00000097,
        32'h40355513, 32'h40151513, 32'h40B56533, 32'h000080E7, 32'h00052583
    };

    initial begin
        exp_t        e;
        logic [7:0]  pat;
        logic        acc;
        int          idx;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b0;

        // Pin the reference decoder against hand-decoded words.
        e = model_decode(32'h40B50533);
        check("model_sub", {e.alu, e.rs1, e.rs2, e.rd}, {4'b1000, 5'd10, 5'd11, 5'd10});
        e = model_decode(32'hFE000EE3);
        check("model_beq_imm", e.imm, 32'hFFFF_FFFC);
        e = model_decode(32'h0080006F);
        check("model_jal_imm", e.imm, 32'h0000_0008);
        e = model_decode(32'h00B52223);
        check("model_sw_imm", e.imm, 32'h0000_0004);
        e = model_decode(32'h40355513);
        check("model_srai_alu", {28'b0, e.alu}, 32'hD);

        repeat (2) step();
        check("reset_in_ready", {31'b0, in_ready}, 32'h0);
        rst_n = 1'b1;
        check("in_ready_before_edge", {31'b0, in_ready}, 32'h0);
        step();
        check("in_ready_after_edge", {31'b0, in_ready}, 32'h1);

        out_ready = 1'b1;
        send_one(32'h40B50533);
        check("sub_valid", {31'b0, out_valid}, 32'h1);
        check("sub_opcode", {25'b0, opcode_reg}, 32'h33);
        check("sub_alu", {28'b0, ALUControl_reg}, 32'h8);
        check("sub_regs", {17'b0, rs1, rs2, rd}, {17'b0, 5'd10, 5'd11, 5'd10});
        check("sub_illegal", {31'b0, illegal}, 32'h0);
        step();

        send_one(32'hFE000EE3);
        check("beq_alu", {28'b0, ALUControl_reg}, 32'h8);
        check("beq_imm", imm, 32'hFFFF_FFFC);
        send_one(32'h40000513);
        check("addi_alu", {28'b0, ALUControl_reg}, 32'h0);
        check("addi_imm", imm, 32'h0000_0400);
        send_one(32'h0000007F);
        check("bad_opc_illegal", {31'b0, illegal}, 32'h1);
        check("bad_opc_alu", {28'b0, ALUControl_reg}, 32'h0);
        send_one(32'h00002063);
        check("bad_branch_illegal", {31'b0, illegal}, 32'h1);
        step();

        // Back-pressure: three offered, two taken.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        step();
        instr = 32'h00200113;
        step();
        check("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        instr = 32'h00300193;
        step();
        check("bp_hold_rd", {27'b0, rd}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_first_imm", imm, 32'd1);
        step();
        check("bp_second_rd", {27'b0, rd}, 32'd2);
        check("bp_second_valid", {31'b0, out_valid}, 32'h1);
        step();
        check("bp_drained", {31'b0, out_valid}, 32'h0);
        check("bp_ready_back", {31'b0, in_ready}, 32'h1);

        // Flush from FULL with a same-cycle offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        step();
        instr = 32'h00200113;
        step();
        flush = 1'b1;
        instr = 32'h00300193;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        check("flush_ready", {31'b0, in_ready}, 32'h1);
        step();
        check("flush_nothing_stored", {31'b0, out_valid}, 32'h0);

        // Mixed stream with a fixed out_ready pattern.
        pat      = 8'b1011_0110;
        idx      = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            instr     = stream[idx];
            out_ready = pat[c % 8];
            acc       = in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stream_all_accepted", idx, 32'd10);
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        send_one(32'h123452B7);
        send_one(32'hFE000EE3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        check("async_rst_ready", {31'b0, in_ready}, 32'h0);
        check("async_rst_imm", imm, 32'h0);
        check("async_rst_fields", {opcode_reg, ALUControl_reg, rs1, rs2, rd, funct3, illegal}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port flush  input  1  synchronous discard of all buffered instructions.
REQ-004 SHALL have port in_valid  input  1  fetch side presents instr.
REQ-005 SHALL have port in_ready  output  1  stage accepts instr this cycle.
REQ-006 SHALL have port instr  input  32  raw RV32I instruction word.
REQ-007 SHALL have port out_valid  output  1  decoded bundle valid.
REQ-008 SHALL have port out_ready  input  1  execute side accepts bundle.
REQ-009 SHALL have port opcode_reg  output  7  instr[6:0], feeding the ALU opcode input.
REQ-010 SHALL have port ALUControl_reg  output  4  ALU operation code, encoded per REQ-019..REQ-022.
REQ-011 SHALL have port imm  output  32  sign-extended immediate.
REQ-012 SHALL have ports rs1, rs2, rd  output  5 each  register indices.
REQ-013 SHALL have port funct3  output  3  instr[14:12], used for load/store width.
REQ-014 SHALL have port illegal  output  1  opcode or funct combination not in RV32I base set.

Function
REQ-015 SHALL decode each accepted instr and present it on the outputs exactly 1 cycle after acceptance when the buffer is empty.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
REQ-016 SHALL implement a 2-entry skid buffer with states EMPTY, ONE, FULL.
- EMPTY -> ONE on transfer in.
- ONE -> FULL on transfer in without transfer out.
- ONE -> EMPTY on transfer out without transfer in.
- ONE -> ONE on simultaneous transfer in and out.
- FULL -> ONE on transfer out.
REQ-017 SHALL drive in_ready = (state != FULL) from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY); outputs SHALL hold stable while out_valid && !out_ready; entries SHALL issue in FIFO order.
REQ-019 For opcodes 0110011 and 0010011, SHALL set ALUControl_reg = {b, funct3}.
- b = instr[30] for R-type, and for 0010011 with funct3=101.
- b = 0 for all other 0010011 encodings (addi instr[30] is immediate data).
REQ-020 For opcode 1100011, SHALL set ALUControl_reg = {1, funct3}.
- funct3 010 and 011 SHALL set illegal.
REQ-021 For opcodes 0000011, 0100011, 1100111, 1101111, 0010111, 0110111, SHALL set ALUControl_reg = 0000.
REQ-022 SHALL set illegal for:
- any other opcode;
- R-type funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
- slli/srli/srai with bad funct7.
An illegal bundle SHALL still transfer normally, with ALUControl_reg = 0000.
REQ-023 SHALL form imm per format:
- I: instr[31:20];
- S: {instr[31:25], instr[11:7]};
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0};
- U: {instr[31:12], 12'b0};
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0};
- R: 0.
All formats SHALL be sign-extended from instr[31].
REQ-024 flush SHALL force state EMPTY on the next edge and SHALL block any same-cycle transfer in from being stored; flush has priority over all transfers.

Reset
REQ-025 While rst_n=0, state SHALL be EMPTY, out_valid=0, in_ready=0, and all data outputs SHALL be 0.
REQ-026 in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.
REQ-027 Assertion of rst_n mid-transfer SHALL discard all entries with no partial bundle visible.

Structure
REQ-028 Opcode constants, ALUControl codes, and the imm-format enumeration SHALL live in shared package rv32_pkg, also used by the ALU.
REQ-029 Decode SHALL be a combinational sub-module rv32_decode_comb, instantiated once on the input side; the buffer stores decoded bundles.

Verification
REQ-030 Decode: instr 0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle out_valid=1, opcode_reg=0110011, ALUControl_reg=1000, rs1=10, rs2=11, rd=10, illegal=0.
REQ-031 Immediate: instr 0xFE000EE3 (beq x0,x0,-4) -> ALUControl_reg=1000, imm=0xFFFFFFFC; instr 0x40000513 (addi a0,x0,1024) -> ALUControl_reg=0000, imm=0x00000400.
REQ-032 Back-pressure: out_ready=0 with 3 back-to-back valid instrs -> 2 accepted, in_ready=0 in the cycle after the 2nd acceptance; out_ready=1 -> both issue in order, then in_ready=1.
REQ-033 Illegal: instr 0x0000007F -> illegal=1, ALUControl_reg=0000; instr 0x00002063 (branch funct3=010) -> illegal=1.
REQ-034 Flush: state FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry stored.
REQ-035 Reset: rst_n low while FULL -> out_valid=0 and outputs 0 immediately, without waiting for a clk edge.
